// File: rtl/com_pkg.sv
// Shared constants and types for the com_block peripheral hub.
// Register map, flag bit positions, UART state encodings, baud helper.
package com_pkg;

  localparam logic [7:0] COM_NONE  = 8'h00;
  localparam logic [7:0] COM_LED   = 8'h01;
  localparam logic [7:0] COM_SW    = 8'h02;
  localparam logic [7:0] COM_KEY   = 8'h03;
  localparam logic [7:0] COM_USTAT = 8'h04;
  localparam logic [7:0] COM_UTX   = 8'h05;
  localparam logic [7:0] COM_URX   = 8'h06;
  localparam logic [7:0] COM_IFLAG = 8'h07;
  localparam logic [7:0] COM_IEN   = 8'h08;

  localparam int FLG_RXV = 0;
  localparam int FLG_TXD = 1;
  localparam int FLG_KEY = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/com_uart_core.sv
// UART0 8N1 transmitter and receiver with baud counters.
// The receive line is synchronised here; data/flags leave as 1-clk pulses.
module uart_core
  import com_pkg::*;
#(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_rx_done,
  output logic       o_rx_ferr,
  output logic [7:0] o_rx_data
);

  localparam int DIV = bit_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_st, w_tx_st_n;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_tx_bit, w_tx_bit_n;
  logic [7:0]    r_tx_sh, w_tx_sh_n;
  logic          r_tx, w_tx_n;
  logic          w_tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_tx_st  <= w_tx_st_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_sh  <= w_tx_sh_n;
      r_tx     <= w_tx_n;
    end
  end

  always_comb begin
    w_tx_st_n  = r_tx_st;
    w_tx_cnt_n = r_tx_cnt;
    w_tx_bit_n = r_tx_bit;
    w_tx_sh_n  = r_tx_sh;
    w_tx_done  = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (i_tx_start) begin
          w_tx_st_n  = TX_START;
          w_tx_cnt_n = '0;
          w_tx_sh_n  = i_tx_data;
        end
      end
      TX_START: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_st_n  = TX_DATA;
          w_tx_cnt_n = '0;
          w_tx_bit_n = '0;
        end else begin
          w_tx_cnt_n = r_tx_cnt + ONE;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_cnt_n = '0;
          w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
          if (r_tx_bit == 3'd7) begin
            w_tx_st_n = TX_STOP;
          end else begin
            w_tx_bit_n = r_tx_bit + 3'd1;
          end
        end else begin
          w_tx_cnt_n = r_tx_cnt + ONE;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == DIV_M1) begin
          w_tx_st_n  = TX_IDLE;
          w_tx_cnt_n = '0;
          w_tx_done  = 1'b1;
        end else begin
          w_tx_cnt_n = r_tx_cnt + ONE;
        end
      end
    endcase
  end

  // Line level follows the next state so the start bit appears one clk after the write
  always_comb begin
    w_tx_n = 1'b1;
    unique case (w_tx_st_n)
      TX_IDLE:  w_tx_n = 1'b1;
      TX_START: w_tx_n = 1'b0;
      TX_DATA:  w_tx_n = w_tx_sh_n[0];
      TX_STOP:  w_tx_n = 1'b1;
    endcase
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = (r_tx_st != TX_IDLE);
  assign o_tx_done = w_tx_done;

  // ---------------- receiver ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t     r_rx_st, w_rx_st_n;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n;
  logic [7:0]    r_rx_sh, w_rx_sh_n;
  logic          w_rx_done, w_rx_ferr;
  logic          w_rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_s1  <= i_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_st  <= w_rx_st_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_sh  <= w_rx_sh_n;
    end
  end

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  always_comb begin
    w_rx_st_n  = r_rx_st;
    w_rx_cnt_n = r_rx_cnt;
    w_rx_bit_n = r_rx_bit;
    w_rx_sh_n  = r_rx_sh;
    w_rx_done  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_st)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_st_n  = RX_START;
          w_rx_cnt_n = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_M1) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          w_rx_st_n  = r_rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_n = r_rx_cnt + ONE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == DIV_M1) begin
          w_rx_cnt_n = '0;
          w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_st_n = RX_STOP;
          end else begin
            w_rx_bit_n = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + ONE;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == DIV_M1) begin
          w_rx_cnt_n = '0;
          if (r_rx_s2) begin
            w_rx_done = 1'b1;
            w_rx_st_n = RX_IDLE;
          end else begin
            w_rx_ferr = 1'b1;
            w_rx_st_n = RX_WAIT;
          end
        end else begin
          w_rx_cnt_n = r_rx_cnt + ONE;
        end
      end
      RX_WAIT: begin
        if (r_rx_s2) w_rx_st_n = RX_IDLE;
      end
      default: w_rx_st_n = RX_IDLE;
    endcase
  end

  assign o_rx_done = w_rx_done;
  assign o_rx_ferr = w_rx_ferr;
  assign o_rx_data = r_rx_sh;

endmodule

// File: rtl/com_block.sv
// Memory-mapped peripheral hub: LEDs, switches, KEY1, UART0, interrupt.
// Side effects fire only on the first cycle a given address is presented.
module com_block
  import com_pkg::*;
#(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       interrupt,
  output logic [7:0] leds,
  input  logic [3:0] switches,
  input  logic       uart0_rx,
  output logic       uart0_tx,
  input  logic       key1
);

  logic [7:0] r_addr_q;
  logic [7:0] r_leds;
  logic [3:0] r_sw1, r_sw2;
  logic       r_k1, r_k2, r_k3;
  logic [2:0] r_ien;
  logic       r_rxv, r_txd, r_key;
  logic       r_ferr;
  logic [7:0] r_rx_data;
  logic       r_irq;

  logic       w_acc;
  logic       w_wr_led, w_wr_utx, w_rd_urx;
  logic       w_wr_iflag, w_wr_ien;
  logic       w_tx_busy, w_tx_done;
  logic       w_rx_done, w_rx_ferr;
  logic [7:0] w_rx_byte;
  logic       w_key_fall;
  logic       w_rxv_n, w_txd_n, w_key_n;
  logic [2:0] w_ien_n;

  assign w_acc      = (addr != r_addr_q);
  assign w_wr_led   = w_acc && (addr == COM_LED);
  assign w_wr_utx   = w_acc && (addr == COM_UTX);
  assign w_rd_urx   = w_acc && (addr == COM_URX);
  assign w_wr_iflag = w_acc && (addr == COM_IFLAG);
  assign w_wr_ien   = w_acc && (addr == COM_IEN);
  assign w_key_fall = r_k3 & ~r_k2;

  uart_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_uart (
    .clk        (clk),
    .rst        (rst),
    .i_tx_start (w_wr_utx && !w_tx_busy),
    .i_tx_data  (in_data),
    .o_tx_busy  (w_tx_busy),
    .o_tx_done  (w_tx_done),
    .o_tx       (uart0_tx),
    .i_rx       (uart0_rx),
    .o_rx_done  (w_rx_done),
    .o_rx_ferr  (w_rx_ferr),
    .o_rx_data  (w_rx_byte)
  );

  // Flag sets take priority over clears landing in the same cycle
  always_comb begin
    w_rxv_n = r_rxv;
    w_txd_n = r_txd;
    w_key_n = r_key;
    w_ien_n = r_ien;
    if (w_rd_urx) w_rxv_n = 1'b0;
    if (w_rx_done) w_rxv_n = 1'b1;
    if (w_wr_iflag && in_data[FLG_TXD]) w_txd_n = 1'b0;
    if (w_tx_done) w_txd_n = 1'b1;
    if (w_wr_iflag && in_data[FLG_KEY]) w_key_n = 1'b0;
    if (w_key_fall) w_key_n = 1'b1;
    if (w_wr_ien) w_ien_n = in_data[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q  <= COM_NONE;
      r_leds    <= '0;
      r_sw1     <= '0;
      r_sw2     <= '0;
      r_k1      <= 1'b1;
      r_k2      <= 1'b1;
      r_k3      <= 1'b1;
      r_ien     <= '0;
      r_rxv     <= 1'b0;
      r_txd     <= 1'b0;
      r_key     <= 1'b0;
      r_ferr    <= 1'b0;
      r_rx_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_addr_q <= addr;
      r_sw1    <= switches;
      r_sw2    <= r_sw1;
      r_k1     <= key1;
      r_k2     <= r_k1;
      r_k3     <= r_k2;
      if (w_wr_led) r_leds <= in_data;
      r_ien <= w_ien_n;
      r_rxv <= w_rxv_n;
      r_txd <= w_txd_n;
      r_key <= w_key_n;
      if (w_rx_done) begin
        r_rx_data <= w_rx_byte;
        r_ferr    <= 1'b0;
      end else if (w_rx_ferr) begin
        r_ferr <= 1'b1;
      end
      r_irq <= |({w_key_n, w_txd_n, w_rxv_n} & w_ien_n);
    end
  end

  always_comb begin
    out_data = 8'h00;
    case (addr)
      COM_LED:   out_data = r_leds;
      COM_SW:    out_data = {4'b0, r_sw2};
      COM_KEY:   out_data = {7'b0, ~r_k2};
      COM_USTAT: out_data = {5'b0, r_ferr, r_rxv, w_tx_busy};
      COM_URX:   out_data = r_rx_data;
      COM_IFLAG: out_data = {5'b0, r_key, r_txd, r_rxv};
      COM_IEN:   out_data = {5'b0, r_ien};
      default:   out_data = 8'h00;
    endcase
  end

  assign leds      = r_leds;
  assign interrupt = r_irq;

endmodule

// File: tb/tb_com_block.sv
// Directed testbench for com_block: registers, UART0 TX/RX, flags, IRQ.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_com_block;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, in_data, out_data;
  logic       interrupt;
  logic [7:0] leds;
  logic [3:0] switches;
  logic       uart0_rx, uart0_tx, key1;

  int n_chk = 0;
  int n_err = 0;
  logic smp [0:1999];

  com_block dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .in_data   (in_data),
    .out_data  (out_data),
    .interrupt (interrupt),
    .leds      (leds),
    .switches  (switches),
    .uart0_rx  (uart0_rx),
    .uart0_tx  (uart0_tx),
    .key1      (key1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    in_data = d;
    tick();
    addr = 8'h00;
    tick();
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, {24'h0, out_data}, {24'h0, exp});
    tick();
    addr = 8'h00;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart0_rx = 1'b0;
    tick(104);
    for (int i = 0; i < 8; i++) begin
      uart0_rx = b[i];
      tick(104);
    end
    uart0_rx = 1'b1;
    tick(104);
  endtask

  initial begin
    logic [9:0] frame;
    int lows;
    int waited;
    rst = 1'b1;
    addr = 8'h00;
    in_data = 8'h00;
    switches = 4'b0000;
    uart0_rx = 1'b1;
    key1 = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();

    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_tx", {31'h0, uart0_tx}, 32'h1);
    chk("rst_irq", {31'h0, interrupt}, 32'h0);
    rd("rst_ustat", 8'h04, 8'h00);
    rd("rst_ien", 8'h08, 8'h00);

    acc(8'h01, 8'hA5);
    chk("led_out", {24'h0, leds}, 32'hA5);
    rd("led_rd", 8'h01, 8'hA5);
    switches = 4'b0110;
    tick(3);
    rd("sw_rd", 8'h02, 8'h06);
    acc(8'h20, 8'hFF);
    rd("unmapped", 8'h20, 8'h00);
    rd("key_idle", 8'h03, 8'h00);

    // TX 0x41 with address held for 2000 clks
    frame = {1'b1, 8'h41, 1'b0};
    addr = 8'h05;
    in_data = 8'h41;
    tick();
    for (int k = 0; k < 2000; k++) begin
      smp[k] = uart0_tx;
      tick();
    end
    addr = 8'h00;
    tick();
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("tx_bit%0d", j), {31'h0, smp[j*104+52]},
          {31'h0, frame[j]});
    end
    chk("tx_start_k0", {31'h0, smp[0]}, 32'h0);
    chk("tx_start_end", {31'h0, smp[103]}, 32'h0);
    chk("tx_bit0_begin", {31'h0, smp[104]}, 32'h1);
    chk("tx_stop_end", {31'h0, smp[1039]}, 32'h1);
    lows = 0;
    for (int k = 0; k < 2000; k++) if (smp[k] == 1'b0) lows++;
    chk("tx_one_frame_lows", lows, 728);
    rd("tx_ustat_idle", 8'h04, 8'h00);
    rd("tx_done_flag", 8'h07, 8'h02);
    acc(8'h07, 8'h02);
    rd("tx_done_clr", 8'h07, 8'h00);

    // Second write while busy must be dropped
    acc(8'h05, 8'h55);
    rd("tx_busy", 8'h04, 8'h01);
    acc(8'h05, 8'hFF);
    addr = 8'h04;
    waited = 0;
    #1;
    while (out_data[0] && waited < 1500) begin
      tick();
      waited++;
    end
    chk("tx_busy_timeout", {31'h0, out_data[0]}, 32'h0);
    addr = 8'h00;
    lows = 0;
    for (int k = 0; k < 1200; k++) begin
      if (uart0_tx == 1'b0) lows++;
      tick();
    end
    chk("tx_drop_busy", lows, 0);
    acc(8'h07, 8'h02);

    // RX 0x5A with rx interrupt enabled
    acc(8'h08, 8'h01);
    send_byte(8'h5A);
    tick(5);
    rd("rx_ustat", 8'h04, 8'h02);
    chk("rx_irq", {31'h0, interrupt}, 32'h1);
    addr = 8'h06;
    #1;
    chk("rx_data", {24'h0, out_data}, 32'h5A);
    tick();
    chk("rx_irq_clr", {31'h0, interrupt}, 32'h0);
    addr = 8'h00;
    tick();
    rd("rx_valid_clr", 8'h04, 8'h00);

    // Stuck-low line from reset: exactly one framing error
    rst = 1'b1;
    uart0_rx = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3000);
    rd("ferr_set", 8'h04, 8'h04);
    rd("ferr_iflag", 8'h07, 8'h00);
    uart0_rx = 1'b1;
    tick(5);
    send_byte(8'h33);
    tick(5);
    rd("ferr_clr", 8'h04, 8'h02);
    rd("rx_33", 8'h06, 8'h33);

    // Short low glitch is rejected in START
    uart0_rx = 1'b0;
    tick(10);
    uart0_rx = 1'b1;
    tick(1200);
    rd("rx_glitch", 8'h04, 8'h00);

    // KEY1 press
    acc(8'h08, 8'h04);
    key1 = 1'b0;
    tick(2);
    chk("key_irq_early", {31'h0, interrupt}, 32'h0);
    tick();
    chk("key_irq", {31'h0, interrupt}, 32'h1);
    rd("key_flag", 8'h07, 8'h04);
    rd("key_pressed", 8'h03, 8'h01);
    acc(8'h07, 8'h04);
    chk("key_irq_clr", {31'h0, interrupt}, 32'h0);
    rd("key_flag_clr", 8'h07, 8'h00);
    key1 = 1'b1;
    tick(3);

    // Reset mid-TX and reset beating a write
    acc(8'h01, 8'h3C);
    acc(8'h05, 8'h00);
    tick(30);
    chk("midtx_low", {31'h0, uart0_tx}, 32'h0);
    rst = 1'b1;
    addr = 8'h01;
    in_data = 8'hFF;
    tick();
    rst = 1'b0;
    addr = 8'h00;
    chk("midtx_leds", {24'h0, leds}, 32'h0);
    chk("midtx_tx", {31'h0, uart0_tx}, 32'h1);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      if (uart0_tx == 1'b0) lows++;
      tick();
    end
    chk("midtx_idle", lows, 0);
    rd("midtx_ustat", 8'h04, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
